// File: rtl/calc_pkg.sv
// Shared types and constants for the sliced add/subtract sequencer.
package calc_pkg;

    localparam int unsigned SLICE_W = 2;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/slice_addsub_seq_if.sv
// Start/done request bus between entry logic and the add/subtract sequencer.
interface slice_addsub_seq_if #(
    parameter int unsigned WIDTH = 6
) ();

    logic             START;
    logic             OP;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] RESULT;
    logic             COUT;
    logic             OVF;
    logic             BUSY;
    logic             DONE;

    modport master (
        output START, OP, A, B,
        input  RESULT, COUT, OVF, BUSY, DONE
    );

    modport slave (
        input  START, OP, A, B,
        output RESULT, COUT, OVF, BUSY, DONE
    );

endinterface

// File: rtl/addsub_slice2.sv
// Combinational 2-bit ripple slice made of two chained full adders.
module addsub_slice2
    import calc_pkg::*;
(
    input  logic [SLICE_W-1:0] a_i,
    input  logic [SLICE_W-1:0] b_i,
    input  logic               cin_i,
    output logic [SLICE_W-1:0] sum_c_o,
    output logic               cout_c_o
);

    logic [SLICE_W:0] carry;

    assign carry[0] = cin_i;

    for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
        assign sum_c_o[i]  = a_i[i] ^ b_i[i] ^ carry[i];
        assign carry[i+1]  = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end

    assign cout_c_o = carry[SLICE_W];

endmodule

// File: rtl/slice_addsub_seq.sv
// Multi-cycle signed add/subtract, one 2-bit slice per cycle, LSB first.
// Optional macro SLICE_ADDSUB_SAT_EN clamps an overflowed result to the signed limit.
module slice_addsub_seq
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH = 6
) (
    input  logic               CLK,
    input  logic               RST_N,
    slice_addsub_seq_if.slave  bus
);

    localparam int unsigned N      = WIDTH / SLICE_W;
    localparam int unsigned IDX_W  = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned BASE_W = $clog2(WIDTH);
    localparam int unsigned MSB    = WIDTH - 1;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [BASE_W-1:0]  base;
    logic [SLICE_W-1:0] a_sl, b_sl, sum_sl;
    logic               co_sl;

    // Current slice operands selected by the slice index.
    assign base = BASE_W'(32'(idx_q) * SLICE_W);
    assign a_sl = a_q[base +: SLICE_W];
    assign b_sl = b_q[base +: SLICE_W];

    addsub_slice2 u_slice (
        .a_i      (a_sl),
        .b_i      (b_sl),
        .cin_i    (carry_q),
        .sum_c_o  (sum_sl),
        .cout_c_o (co_sl)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.START) begin
                    a_d      = bus.A;
                    b_d      = (bus.OP == OP_SUB) ? ~bus.B : bus.B;
                    carry_d  = (bus.OP == OP_SUB);
                    idx_d    = '0;
                    result_d = '0;
                    cout_d   = 1'b0;
                    ovf_d    = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                result_d[base +: SLICE_W] = sum_sl;
                carry_d = co_sl;
                idx_d   = idx_q + IDX_W'(1);
                // The last slice carries the MSB, so sum_sl[1] is the final sign bit.
                if (idx_q == IDX_W'(N - 1)) begin
                    cout_d  = co_sl;
                    ovf_d   = (a_q[MSB] == b_q[MSB]) && (sum_sl[SLICE_W-1] != a_q[MSB]);
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
`ifdef SLICE_ADDSUB_SAT_EN
                    if (ovf_d) begin
                        result_d = a_q[MSB] ? {1'b1, {(WIDTH-1){1'b0}}}
                                            : {1'b0, {(WIDTH-1){1'b1}}};
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.RESULT = result_q;
    assign bus.COUT   = cout_q;
    assign bus.OVF    = ovf_q;
    assign bus.BUSY   = busy_q;
    assign bus.DONE   = done_q;

endmodule
